// File: rtl/fetch_prefetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack channel, execute redirect,
// and the valid/ready head channel towards decode.
interface fetch_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: owns the fetch PC, prefetches into a DEPTH-entry FIFO.
// Define FETCH_BYPASS_EN to forward an ack straight to decode when the FIFO is empty.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                   clk,
  input logic                   rst,
  fetch_prefetch_unit_if.master bus
);
  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [1:0]       IDLE    = 2'd0;
  localparam logic [1:0]       BUSY    = 2'd1;
  localparam logic [1:0]       DROP    = 2'd2;

  logic [1:0]       state_r, stateNext_s;
  logic [31:0]      fetchPc_r, fetchPcNext_s;
  logic [31:0]      addr_r, addrNext_s;
  logic [CNT_W-1:0] count_r, countNext_s;
  logic [PTR_W-1:0] rdPtr_r, wrPtr_r;
  logic [31:0]      memInstr_r [DEPTH];
  logic [31:0]      memPc_r    [DEPTH];
  logic [31:0]      memPc4_r   [DEPTH];
  logic             ackData_s, bypass_s, push_s, pop_s, advancePc_s;

  assign ackData_s = (state_r == BUSY) && bus.imem_ack && !bus.redirect;

  // Bypass qualification, FIFO push/pop and next occupancy
  always_comb begin
`ifdef FETCH_BYPASS_EN
    bypass_s = ackData_s && (count_r == {CNT_W{1'b0}});
`else
    bypass_s = 1'b0;
`endif
    pop_s  = (count_r != {CNT_W{1'b0}}) && bus.instr_ready && !bus.redirect;
    push_s = ackData_s && !(bypass_s && bus.instr_ready);
    if (bus.redirect) begin
      countNext_s = {CNT_W{1'b0}};
    end else begin
      countNext_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
    end
  end

  // Request sequencing; the stale request keeps addr/req stable until its ack
  always_comb begin
    stateNext_s = state_r;
    addrNext_s  = addr_r;
    advancePc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.redirect && (count_r < FULL_C)) begin
          stateNext_s = BUSY;
          addrNext_s  = fetchPc_r;
        end else begin
          stateNext_s = IDLE;
        end
      end
      BUSY: begin
        if (ackData_s) begin
          advancePc_s = 1'b1;
          if (countNext_s < FULL_C) begin
            stateNext_s = BUSY;
            addrNext_s  = addr_r + 32'd4;
          end else begin
            stateNext_s = IDLE;
          end
        end else if (bus.redirect) begin
          stateNext_s = bus.imem_ack ? IDLE : DROP;
        end else begin
          stateNext_s = BUSY;
        end
      end
      DROP: begin
        stateNext_s = bus.imem_ack ? IDLE : DROP;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  assign fetchPcNext_s = bus.redirect ? bus.redirect_pc :
                         (advancePc_s ? addr_r + 32'd4 : fetchPc_r);

  // FSM state, fetch PC and outstanding request address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      fetchPc_r <= RESET_PC;
      addr_r    <= 32'h0;
    end else begin
      state_r   <= stateNext_s;
      fetchPc_r <= fetchPcNext_s;
      addr_r    <= addrNext_s;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CNT_W{1'b0}};
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
    end else if (bus.redirect) begin
      count_r <= {CNT_W{1'b0}};
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
    end else begin
      count_r <= countNext_s;
      rdPtr_r <= pop_s  ? rdPtr_r + PTR_ONE : rdPtr_r;
      wrPtr_r <= push_s ? wrPtr_r + PTR_ONE : wrPtr_r;
    end
  end

  // FIFO storage: instruction word with its PC and PC+4
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        memInstr_r[i] <= 32'h0;
        memPc_r[i]    <= 32'h0;
        memPc4_r[i]   <= 32'h0;
      end
    end else if (push_s) begin
      memInstr_r[wrPtr_r] <= bus.imem_rdata;
      memPc_r[wrPtr_r]    <= addr_r;
      memPc4_r[wrPtr_r]   <= addr_r + 32'd4;
    end
  end

  assign bus.imem_req  = (state_r != IDLE);
  assign bus.imem_addr = addr_r;

  // Head presentation: FIFO read pointer, or the ack data when bypassing
  always_comb begin
    bus.instr_valid = (count_r != {CNT_W{1'b0}}) || bypass_s;
    if (bypass_s) begin
      bus.instr     = bus.imem_rdata;
      bus.instr_pc  = addr_r;
      bus.instr_pc4 = addr_r + 32'd4;
    end else begin
      bus.instr     = memInstr_r[rdPtr_r];
      bus.instr_pc  = memPc_r[rdPtr_r];
      bus.instr_pc4 = memPc4_r[rdPtr_r];
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: a queue-level model of the fetch stream
// is compared against the DUT every cycle, plus hand-computed directed scenarios.
module tb_fetch_prefetch_unit;
  localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {logic [31:0] ins; logic [31:0] pc;} ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if bus();

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int tests = 0;
  int fails = 0;

  // Model: words awaiting decode, next PC to fetch, expected request and stale flag
  ent_t        q[$];
  logic [31:0] expFetch, expAddr;
  logic        expReq, stale;

  logic        sReq, sValid;
  logic [31:0] sAddr, sInstr, sPc, sPc4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    expFetch = 32'h0;
    expAddr  = 32'h0;
    expReq   = 1'b0;
    stale    = 1'b0;
  endtask

  // Called at a falling edge; leaves at the next falling edge
  task automatic step(input int ackMode, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input logic [31:0] rdat);
    logic        ackV, goodAck, expValid, consumed, nReq;
    logic [31:0] nAddr;
    int          qBefore;
    ent_t        head;
    ackV = 1'b0;
    if (bus.imem_req && ackMode == 1) ackV = 1'b1;
    if (bus.imem_req && ackMode == 2) ackV = ($urandom_range(0, 1) == 1);
    bus.imem_ack    = ackV;
    bus.imem_rdata  = rdat;
    bus.instr_ready = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
    sReq = bus.imem_req;  sAddr = bus.imem_addr;  sValid = bus.instr_valid;
    sInstr = bus.instr;   sPc = bus.instr_pc;     sPc4 = bus.instr_pc4;

    goodAck  = sReq && ackV && !stale && !redir;
    expValid = (q.size() != 0) || (BYP && goodAck);
    head     = (q.size() != 0) ? q[0] : {rdat, sAddr};
    check("req", {31'h0, sReq}, {31'h0, expReq});
    if (sReq && expReq) check("addr", sAddr, expAddr);
    check("valid", {31'h0, sValid}, {31'h0, expValid});
    if (sValid && expValid) begin
      check("instr", sInstr, head.ins);
      check("pc", sPc, head.pc);
      check("pc4", sPc4, head.pc + 32'd4);
    end

    qBefore  = q.size();
    consumed = 1'b0;
    if (expValid && rdy && !redir) begin
      if (q.size() != 0) void'(q.pop_front());
      else consumed = 1'b1;
    end
    if (goodAck && !consumed) q.push_back({rdat, sAddr});

    if (sReq && !ackV) begin
      nReq = 1'b1; nAddr = sAddr;
    end else if (goodAck && q.size() < DEPTH) begin
      nReq = 1'b1; nAddr = sAddr + 32'd4;
    end else if (!sReq && !redir && qBefore < DEPTH) begin
      nReq = 1'b1; nAddr = expFetch;
    end else begin
      nReq = 1'b0; nAddr = expAddr;
    end

    if (sReq && ackV) begin
      stale = 1'b0;
      if (goodAck) expFetch = sAddr + 32'd4;
    end
    if (redir) begin
      q.delete();
      expFetch = rpc;
      if (sReq && !ackV) stale = 1'b1;
    end
    expReq  = nReq;
    expAddr = nAddr;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_req", {31'h0, bus.imem_req}, 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_pc", bus.instr_pc, 32'h0);
    check("rst_pc4", bus.instr_pc4, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  initial begin
    // Streaming from reset with ack every cycle
    doReset();
    step(1, 1'b1, 1'b0, 32'h0, 32'h11);
    step(1, 1'b1, 1'b0, 32'h0, 32'h22);
    check("a_req", {31'h0, sReq}, 32'h1);
    check("a_addr0", sAddr, 32'h0);
    step(1, 1'b1, 1'b0, 32'h0, 32'h33);
    check("a_addr4", sAddr, 32'h4);
    if (!BYP) check("a_pc0", sPc, 32'h0);
    step(1, 1'b1, 1'b0, 32'h0, 32'h44);
    check("a_addr8", sAddr, 32'h8);
    if (!BYP) check("a_pc4", sPc, 32'h4);

    // Decode stall fills the FIFO, then drains and fetch resumes at 8
    doReset();
    for (int i = 0; i < 5; i++) step(1, 1'b0, 1'b0, 32'h0, $urandom);
    check("b_req_off", {31'h0, sReq}, 32'h0);
    check("b_valid", {31'h0, sValid}, 32'h1);
    check("b_head0", sPc, 32'h0);
    step(1, 1'b1, 1'b0, 32'h0, $urandom);
    check("b_pop0", sPc, 32'h0);
    step(1, 1'b1, 1'b0, 32'h0, $urandom);
    check("b_pop4", sPc, 32'h4);
    step(1, 1'b1, 1'b0, 32'h0, $urandom);
    check("b_resume_req", {31'h0, sReq}, 32'h1);
    check("b_resume_addr", sAddr, 32'h8);

    // Redirect while the request for 8 is outstanding
    doReset();
    for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b0, 32'h0, $urandom);
    step(0, 1'b1, 1'b1, 32'h100, $urandom);
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    check("c_drop_req", {31'h0, sReq}, 32'h1);
    check("c_drop_addr", sAddr, 32'h8);
    check("c_flushed", {31'h0, sValid}, 32'h0);
    step(1, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF);
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    check("c_idle", {31'h0, sReq}, 32'h0);
    step(1, 1'b1, 1'b0, 32'h0, 32'h13);
    check("c_new_addr", sAddr, 32'h100);
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    if (!BYP) check("c_new_pc", sPc, 32'h100);

    // Redirect together with ack and pop
    doReset();
    step(1, 1'b1, 1'b0, 32'h0, $urandom);
    step(1, 1'b1, 1'b0, 32'h0, $urandom);
    step(1, 1'b1, 1'b1, 32'h200, $urandom);
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    check("d_valid", {31'h0, sValid}, 32'h0);
    check("d_req", {31'h0, sReq}, 32'h0);
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    check("d_addr", sAddr, 32'h200);

    // PC wrap-around at the top of the address space
    doReset();
    step(0, 1'b1, 1'b1, 32'hFFFFFFFC, $urandom);
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    check("e_req", {31'h0, sReq}, 32'h0);
    step(1, 1'b1, 1'b0, 32'h0, $urandom);
    check("e_addr", sAddr, 32'hFFFFFFFC);
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    check("e_next_addr", sAddr, 32'h0);
    if (!BYP) check("e_pc", sPc, 32'hFFFFFFFC);
    if (!BYP) check("e_pc4", sPc4, 32'h0);

`ifdef FETCH_BYPASS_EN
    // Same-cycle forwarding into an empty FIFO
    doReset();
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    step(1, 1'b1, 1'b0, 32'h0, 32'h00500093);
    check("f_valid", {31'h0, sValid}, 32'h1);
    check("f_instr", sInstr, 32'h00500093);
    check("f_pc", sPc, 32'h0);
    step(0, 1'b1, 1'b0, 32'h0, $urandom);
    check("f_empty", {31'h0, sValid}, 32'h0);
`endif

    // Random traffic: variable latency, stalls and redirects
    doReset();
    for (int i = 0; i < 4000; i++) begin
      logic        r;
      logic [31:0] p;
      r = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      step(2, ($urandom_range(0, 3) != 0), r, p, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
